// File: rtl/sysid_regbank.sv
// sysid_regbank: Avalon-MM system-ID slave (ID, timestamp, uptime, scratch, ctrl, version).
// Latency: READ_LATENCY edges from accepted read to the readdatavalid pulse.
// Backpressure: none; one read or write is accepted every cycle, and a write wins over a coincident read.
//
// Ports:
//   clock, reset             rising-edge clock, synchronous active-high reset
//   address[2:0]             word address
//   read, write, writedata   Avalon-MM request side
//   readdata, readdatavalid  registered response; readdata is 0 whenever readdatavalid is 0
//
// Build option: define SYSID_UPTIME_EN to include the prescaled 64-bit uptime counter,
// its HI snapshot and the CTRL register. Without it those addresses read 0 and ignore writes.
module sysid_regbank #(
  parameter logic [31:0] ID           = 32'h6943_3637,
  parameter logic [31:0] TIMESTAMP    = 32'h0,
  parameter int unsigned PRESCALE     = 1,
  parameter int unsigned READ_LATENCY = 1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [2:0]  address,
  input  logic        read,
  input  logic        write,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic        readdatavalid
);

`ifdef SYSID_UPTIME_EN
  localparam bit UPTIME_PRESENT = 1'b1;
`else
  localparam bit UPTIME_PRESENT = 1'b0;
`endif

  // VERSION[15:0] advertises the prescaler only when the counter exists.
  localparam logic [15:0] VERSION_LO = UPTIME_PRESENT ? 16'(PRESCALE) : 16'h0000;

  logic                          rd_acc;
  logic [31:0]                   scratch_q, scratch_d;
  logic [31:0]                   rdata_mux;
  logic [READ_LATENCY-1:0]       rvld_q, rvld_d;
  logic [READ_LATENCY-1:0][31:0] rdat_q, rdat_d;

  // A read colliding with a write is dropped entirely.
  assign rd_acc = read & ~write;

  always_comb begin
    scratch_d = scratch_q;
    if (write && (address == 3'd4)) begin
      scratch_d = writedata;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      scratch_q <= '0;
    end else begin
      scratch_q <= scratch_d;
    end
  end

`ifdef SYSID_UPTIME_EN
  localparam logic [15:0] PRESC_MAX = 16'(PRESCALE - 1);

  logic [15:0] presc_q, presc_d;
  logic [63:0] uptime_q, uptime_d;
  logic [31:0] snap_q, snap_d;
  logic        en_q, en_d;
  logic        ctrl_wr;
  logic        clr;

  always_comb begin
    ctrl_wr  = write && (address == 3'd5);
    clr      = ctrl_wr && writedata[1];
    en_d     = ctrl_wr ? writedata[0] : en_q;
    presc_d  = presc_q;
    uptime_d = uptime_q;
    snap_d   = snap_q;
    // Reading LO freezes the matching HI half so a LO-then-HI pair is coherent.
    if (rd_acc && (address == 3'd2)) begin
      snap_d = uptime_q[63:32];
    end
    if (en_q) begin
      if (presc_q == PRESC_MAX) begin
        presc_d  = '0;
        uptime_d = uptime_q + 64'd1;
      end else begin
        presc_d = presc_q + 16'd1;
      end
    end
    // Clear overrides any increment or snapshot in the same cycle.
    if (clr) begin
      presc_d  = '0;
      uptime_d = '0;
      snap_d   = '0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      presc_q  <= '0;
      uptime_q <= '0;
      snap_q   <= '0;
      en_q     <= 1'b1;
    end else begin
      presc_q  <= presc_d;
      uptime_q <= uptime_d;
      snap_q   <= snap_d;
      en_q     <= en_d;
    end
  end
`endif

  // Read data is taken from the register state of the accepting cycle.
  always_comb begin
    rdata_mux = '0;
    case (address)
      3'd0:    rdata_mux = ID;
      3'd1:    rdata_mux = TIMESTAMP;
`ifdef SYSID_UPTIME_EN
      3'd2:    rdata_mux = uptime_q[31:0];
      3'd3:    rdata_mux = snap_q;
      3'd5:    rdata_mux = {31'd0, en_q};
`endif
      3'd4:    rdata_mux = scratch_q;
      3'd6:    rdata_mux = {8'h02, 8'h00, VERSION_LO};
      default: rdata_mux = '0;
    endcase
  end

  // Response shift register; data travels zeroed when its valid bit is clear.
  always_comb begin
    rvld_d    = '0;
    rdat_d    = '0;
    rvld_d[0] = rd_acc;
    rdat_d[0] = rd_acc ? rdata_mux : 32'd0;
    for (int i = 1; i < READ_LATENCY; i++) begin
      rvld_d[i] = rvld_q[i-1];
      rdat_d[i] = rdat_q[i-1];
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      rvld_q <= '0;
      rdat_q <= '0;
    end else begin
      rvld_q <= rvld_d;
      rdat_q <= rdat_d;
    end
  end

  assign readdatavalid = rvld_q[READ_LATENCY-1];
  assign readdata      = rdat_q[READ_LATENCY-1];

endmodule

// File: tb/tb_sysid_regbank.sv
// Directed bench for sysid_regbank: PRESCALE=4, READ_LATENCY=2.
// Inputs are driven and outputs sampled on the falling edge.
// Counter checks run when SYSID_UPTIME_EN is defined, disabled-build checks otherwise.
module tb_sysid_regbank;

  localparam logic [31:0] ID_VAL = 32'h6943_3637;
  localparam logic [31:0] TS_VAL = 32'h6612_3456;
  localparam int          PRESC  = 4;
  localparam int          LAT    = 2;
`ifdef SYSID_UPTIME_EN
  localparam logic [31:0] VER_VAL = 32'h0200_0004;
`else
  localparam logic [31:0] VER_VAL = 32'h0200_0000;
`endif

  logic        clock;
  logic        reset;
  logic [2:0]  address;
  logic        read;
  logic        write;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic        readdatavalid;

  int n_tests = 0;
  int n_fail  = 0;

  sysid_regbank #(
    .ID           (ID_VAL),
    .TIMESTAMP    (TS_VAL),
    .PRESCALE     (PRESC),
    .READ_LATENCY (LAT)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .address       (address),
    .read          (read),
    .write         (write),
    .writedata     (writedata),
    .readdata      (readdata),
    .readdatavalid (readdatavalid)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Leaves the bench at the falling edge of cycle 0 (first cycle with reset low).
  task automatic do_reset();
    reset = 1'b1;
    read  = 1'b0;
    write = 1'b0;
    repeat (2) @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    write     = 1'b1;
    address   = a;
    writedata = d;
    @(negedge clock);
    write = 1'b0;
  endtask

  task automatic rd_get(input string tag, input logic [2:0] a, output logic [31:0] d);
    read    = 1'b1;
    address = a;
    @(negedge clock);
    read = 1'b0;
    repeat (LAT - 1) @(negedge clock);
    check({tag, "_vld"}, {31'd0, readdatavalid}, 32'd1);
    d = readdata;
  endtask

  task automatic rd(input string tag, input logic [2:0] a, input logic [31:0] exp);
    logic [31:0] d;
    rd_get(tag, a, d);
    check(tag, d, exp);
  endtask

  initial begin
    logic [31:0] junk;
    reset     = 1'b1;
    read      = 1'b0;
    write     = 1'b0;
    address   = 3'd0;
    writedata = 32'd0;
    repeat (3) @(negedge clock);
    check("rst_vld", {31'd0, readdatavalid}, 32'd0);
    check("rst_dat", readdata, 32'd0);
    reset = 1'b0;

    // Back-to-back reads of ID, TIMESTAMP, VERSION.
    read = 1'b1; address = 3'd0;
    @(negedge clock);
    check("b2b_pre_vld", {31'd0, readdatavalid}, 32'd0);
    check("b2b_pre_dat", readdata, 32'd0);
    address = 3'd1;
    @(negedge clock);
    check("b2b_id_vld", {31'd0, readdatavalid}, 32'd1);
    check("b2b_id", readdata, ID_VAL);
    address = 3'd6;
    @(negedge clock);
    read = 1'b0;
    check("b2b_ts_vld", {31'd0, readdatavalid}, 32'd1);
    check("b2b_ts", readdata, TS_VAL);
    @(negedge clock);
    check("b2b_ver_vld", {31'd0, readdatavalid}, 32'd1);
    check("b2b_ver", readdata, VER_VAL);
    @(negedge clock);
    check("b2b_post_vld", {31'd0, readdatavalid}, 32'd0);
    check("b2b_post_dat", readdata, 32'd0);

    // Scratch and read-only addresses.
    wr(3'd4, 32'hDEAD_BEEF);
    rd("scratch", 3'd4, 32'hDEAD_BEEF);
    wr(3'd0, 32'h1234_5678);
    rd("id_ro", 3'd0, ID_VAL);
    wr(3'd6, 32'hFFFF_FFFF);
    rd("ver_ro", 3'd6, VER_VAL);
    wr(3'd7, 32'hA5A5_A5A5);
    rd("addr7", 3'd7, 32'd0);

    // Simultaneous read and write: write lands, no response.
    read = 1'b1; write = 1'b1; address = 3'd4; writedata = 32'h0BAD_F00D;
    @(negedge clock);
    read = 1'b0; write = 1'b0;
    check("rw_vld1", {31'd0, readdatavalid}, 32'd0);
    @(negedge clock);
    check("rw_vld2", {31'd0, readdatavalid}, 32'd0);
    rd("rw_scratch", 3'd4, 32'h0BAD_F00D);

    // Reset with reads in flight drops them.
    read = 1'b1; address = 3'd0;
    @(negedge clock);
    address = 3'd1;
    @(negedge clock);
    read = 1'b0;
    check("inflight_first", {31'd0, readdatavalid}, 32'd1);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    check("inflight_vld1", {31'd0, readdatavalid}, 32'd0);
    check("inflight_dat1", readdata, 32'd0);
    @(negedge clock);
    check("inflight_vld2", {31'd0, readdatavalid}, 32'd0);
    rd("rst_scratch", 3'd4, 32'd0);

`ifdef SYSID_UPTIME_EN
    rd("rst_ctrl", 3'd5, 32'd1);
    rd("rst_hi", 3'd3, 32'd0);

    // Uptime at cycle 40 with PRESCALE=4 is 10.
    do_reset();
    repeat (40) @(negedge clock);
    rd("up40", 3'd2, 32'd10);
    wr(3'd5, 32'd0);
    rd("ctrl_en0", 3'd5, 32'd0);
    repeat (20) @(negedge clock);
    rd("frozen", 3'd2, 32'd10);

    // Re-enable; the next cycle is a terminal count, and CLR lands on it.
    wr(3'd5, 32'd1);
    wr(3'd5, 32'd3);
    rd("clr0", 3'd2, 32'd0);
    repeat (2) @(negedge clock);
    rd("clr1", 3'd2, 32'd1);
    repeat (2) @(negedge clock);
    rd("clr2", 3'd2, 32'd2);
    rd("ctrl_after_clr", 3'd5, 32'd1);

    // Snapshot coherence across the 32-bit carry.
    force dut.uptime_q = 64'h0000_0000_FFFF_FFFF;
    read = 1'b1; address = 3'd2;
    @(negedge clock);
    release dut.uptime_q;
    read = 1'b0;
    repeat (LAT - 1) @(negedge clock);
    check("wrap_lo_vld", {31'd0, readdatavalid}, 32'd1);
    check("wrap_lo", readdata, 32'hFFFF_FFFF);
    repeat (5) @(negedge clock);
    rd("wrap_hi_snap", 3'd3, 32'd0);
    repeat (8) @(negedge clock);
    rd_get("wrap_lo2", 3'd2, junk);
    rd("wrap_hi_live", 3'd3, 32'd1);
`else
    repeat (10) @(negedge clock);
    rd("dis_lo", 3'd2, 32'd0);
    wr(3'd2, 32'h1111_1111);
    rd("dis_lo_wr", 3'd2, 32'd0);
    rd("dis_hi", 3'd3, 32'd0);
    wr(3'd5, 32'd3);
    rd("dis_ctrl", 3'd5, 32'd0);
    wr(3'd4, 32'h5555_AAAA);
    rd("dis_scratch", 3'd4, 32'h5555_AAAA);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/sysid_regbank.md
# sysid_regbank

Parametrised system-identification slave for the Qsys system: a small Avalon-MM register bank that returns a build ID and timestamp, plus a free-running prescaled uptime counter with coherent 64-bit snapshot reads, a scratch register and a control register. Read latency is configurable with a `readdatavalid` pipeline. It replaces the single-word, address-decoded ID constant in new system builds; software probes it at boot to identify the FPGA image.

## Interface
- `ID`, 32'h6943_3637 — system ID word returned at register 0.
- `TIMESTAMP`, 32'h0 — build timestamp (Unix seconds), register 1.
- `PRESCALE`, 1 — clock cycles per uptime increment; legal 1..65535.
- `READ_LATENCY`, 1 — cycles from accepted read to `readdatavalid`; legal 1..4.
- `clock`  in  1  system clock; all logic on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `address`  in  3  word address.
- `read`  in  1  read strobe; one read accepted per cycle, no waitrequest.
- `write`  in  1  write strobe.
- `writedata`  in  32  write data.
- `readdata`  out  32  read data, valid only while `readdatavalid`=1.
- `readdatavalid`  out  1  one-cycle pulse per accepted read.

## Operation
- Register map (word address):
  - 0 ID (RO); 1 TIMESTAMP (RO).
  - 2 UPTIME_LO (RO): returns counter[31:0] and, in the same cycle, latches counter[63:32] into the HI snapshot.
  - 3 UPTIME_HI (RO): returns the snapshot, not the live counter.
  - 4 SCRATCH (RW, 32 bit).
  - 5 CTRL: bit0 EN (RW, reset 1); bit1 CLR (WO, self-clearing, reads 0); other bits read 0.
  - 6 VERSION (RO): {8'h02, 8'd0, PRESCALE[15:0]}.
  - 7 reads 0; writes ignored.
- Writes to RO addresses are ignored.
- If `read` and `write` are both asserted, the write is performed; the read is ignored and no `readdatavalid` is produced.
- Prescaler: counts 0..PRESCALE-1 while EN=1. On the terminal count it wraps to 0 and increments the 64-bit uptime. PRESCALE=1 increments every cycle. EN=0 freezes both prescaler and uptime.
- Uptime wraps from 2^64-1 to 0 without a flag.
- CLR write: zeroes uptime, prescaler and HI snapshot on the next edge. Clear wins over a coincident increment. The EN bit in the same write is applied as written.

## Timing
- Reset: `readdata`=0, `readdatavalid`=0, uptime=0, prescaler=0, snapshot=0, SCRATCH=0, EN=1. All in-flight reads are dropped.
- Read accepted at edge N; `readdata`/`readdatavalid` presented after edge N+READ_LATENCY-1+1, i.e. visible for the one cycle following READ_LATENCY edges. Back-to-back reads give back-to-back valid pulses in order.
- Read data is sampled at acceptance:
  - UPTIME_LO returns the pre-increment/pre-clear value of that cycle.
  - A SCRATCH read in the cycle after a write returns the new value.
- `readdata` returns to 0 whenever `readdatavalid`=0.
- Uptime value at cycle k after reset (EN=1): floor(k/PRESCALE).

## Configuration
- `SYSID_UPTIME_EN` defined: prescaler, 64-bit counter, snapshot and CTRL implemented as above.
- Undefined: no counter logic is synthesised; addresses 2, 3 and 5 read 0 and ignore writes; VERSION[15:0] reads 0. ID, TIMESTAMP, SCRATCH and read latency behave identically.

## Test plan
- Reset, then read addresses 0, 1 and 6 back-to-back with READ_LATENCY=2 -> three consecutive valid pulses starting 2 cycles after the first read, with data ID, TIMESTAMP and {8'h02, 8'd0, PRESCALE}; `readdata`=0 between pulses.
- Write 32'hDEADBEEF to SCRATCH, then read it the next cycle -> 32'hDEADBEEF. Write to address 0 -> ID unchanged.
- PRESCALE=4, EN=1. Read UPTIME_LO at cycle 40 after reset -> 10. Clear EN, wait 20 cycles, read again -> unchanged.
- Force uptime to 64'h0000_0000_FFFF_FFFF (PRESCALE=1). Read LO at the wrap edge, then HI 5 cycles later -> LO=32'hFFFF_FFFF, HI=0 (snapshot coherent, not live 1).
- Write CTRL=3 (CLR+EN) in the same cycle as an increment -> uptime 0 the next cycle, then counts 1, 2, … Assert `reset` with 2 reads in flight -> no `readdatavalid` after reset.
- Compile without `SYSID_UPTIME_EN`: read address 2 -> 0, VERSION[15:0]=0, SCRATCH still R/W.
